// File: rtl/barrel_arb.sv
// barrel_arb: two-requester round-robin arbiter in front of one shared
// 8-bit logical barrel shifter, with a one-entry output holding register.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rX_valid / rX_ready  requester X handshake (X = 0, 1)
//   rX_in, rX_k, rX_dir  operand, shift amount, direction (1 = left)
//   out_valid/out_ready  result handshake
//   out_data, out_id     shifted result and index of its requester
//   gnt_cnt0, gnt_cnt1   wrapping 8-bit count of accepted operations
module barrel_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [7:0]       r0_in,
  input  logic [WIDTH-1:0] r0_k,
  input  logic             r0_dir,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [7:0]       r1_in,
  input  logic [WIDTH-1:0] r1_k,
  input  logic             r1_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_id,
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic       r_last;
  logic [7:0] r_data;
  logic       r_id;
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  logic             w_can;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic [7:0]       w_op_in;
  logic [WIDTH-1:0] w_op_k;
  logic             w_op_dir;
  logic [7:0]       w_shift;

  // r_last holds the requester granted most recently; on a tie the
  // other one wins.
  assign w_gnt0 = r0_valid & (~r1_valid | r_last);
  assign w_gnt1 = r1_valid & (~r0_valid | ~r_last);

  assign w_can = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
  assign w_acc = w_can & (w_gnt0 | w_gnt1) & ~rst;

  assign r0_ready = w_can & w_gnt0 & ~rst;
  assign r1_ready = w_can & w_gnt1 & ~rst;

  // Single shared shifter; operands chosen by the grant.
  assign w_op_in  = w_gnt1 ? r1_in  : r0_in;
  assign w_op_k   = w_gnt1 ? r1_k   : r0_k;
  assign w_op_dir = w_gnt1 ? r1_dir : r0_dir;

  // A shift by 8 or more moves every bit out, yielding zero.
  assign w_shift = w_op_dir ? (w_op_in << w_op_k)
                            : (w_op_in >> w_op_k);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_state_nxt = HOLD;
      HOLD: begin
        if (w_acc)          w_state_nxt = HOLD;
        else if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_data  <= 8'h00;
      r_id    <= 1'b0;
      r_cnt0  <= 8'h00;
      r_cnt1  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_data <= w_shift;
        r_id   <= w_gnt1;
        r_last <= w_gnt1;
        if (w_gnt0) r_cnt0 <= r_cnt0 + 8'd1;
        if (w_gnt1) r_cnt1 <= r_cnt1 + 8'd1;
      end
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign gnt_cnt0  = r_cnt0;
  assign gnt_cnt1  = r_cnt1;

endmodule

// File: tb/tb_barrel_arb.sv
// tb_barrel_arb: directed checks of barrel_arb.
// Inputs change on the falling edge; outputs are sampled away from it.
module tb_barrel_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r0_ready, r0_dir;
  logic [7:0] r0_in;
  logic [3:0] r0_k;
  logic       r1_valid, r1_ready, r1_dir;
  logic [7:0] r1_in;
  logic [3:0] r1_k;
  logic       out_valid, out_ready, out_id;
  logic [7:0] out_data, gnt_cnt0, gnt_cnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  barrel_arb #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready),
    .r0_in(r0_in), .r0_k(r0_k), .r0_dir(r0_dir),
    .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r1_in(r1_in), .r1_k(r1_k), .r1_dir(r1_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One single-requester operation; the operand is corrupted after
  // acceptance to show the held result does not follow it.
  task automatic op(input logic id, input logic [7:0] din,
                    input logic [3:0] k, input logic dir,
                    input logic [7:0] exp);
    @(negedge clk);
    if (id) begin
      r1_valid = 1; r1_in = din; r1_k = k; r1_dir = dir;
    end else begin
      r0_valid = 1; r0_in = din; r0_k = k; r0_dir = dir;
    end
    #1;
    check("op_rdy0", r0_ready, !id);
    check("op_rdy1", r1_ready, id);
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    r0_in = 8'hFF; r1_in = 8'hFF;
    #1;
    check("op_valid", out_valid, 1);
    check("op_data", out_data, exp);
    check("op_id", out_id, id);
  endtask

  initial begin
    rst = 1; out_ready = 1;
    r0_valid = 0; r0_in = 0; r0_k = 0; r0_dir = 0;
    r1_valid = 0; r1_in = 0; r1_k = 0; r1_dir = 0;
    repeat (2) @(negedge clk);
    r0_valid = 1; r1_valid = 1;
    #1;
    check("rst_rdy0", r0_ready, 0);
    check("rst_rdy1", r1_ready, 0);
    @(negedge clk);
    rst = 0; r0_valid = 0; r1_valid = 0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_id", out_id, 0);
    check("rst_cnt0", gnt_cnt0, 0);
    check("rst_cnt1", gnt_cnt1, 0);

    op(0, 8'h55, 4'd1, 1, 8'hAA);
    op(1, 8'h55, 4'd1, 0, 8'h2A);
    op(1, 8'h55, 4'd2, 1, 8'h54);
    op(1, 8'h55, 4'd4, 0, 8'h05);
    op(0, 8'h55, 4'd9, 1, 8'h00);
    op(1, 8'hFF, 4'd9, 0, 8'h00);
    op(0, 8'h81, 4'd7, 0, 8'h01);
    check("cnt0_a", gnt_cnt0, 3);
    check("cnt1_a", gnt_cnt1, 4);

    // Fresh reset, then a continuous tie: grants alternate from r0.
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    r0_valid = 1; r0_in = 8'h01; r0_k = 0; r0_dir = 0;
    r1_valid = 1; r1_in = 8'h02; r1_k = 0; r1_dir = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy0", r0_ready, (i % 2) == 0);
      check("rr_rdy1", r1_ready, (i % 2) == 1);
      @(negedge clk);
      #1;
      check("rr_valid", out_valid, 1);
      check("rr_id", out_id, i % 2);
    end
    check("rr_cnt0", gnt_cnt0, 2);
    check("rr_cnt1", gnt_cnt1, 2);

    // Stall in HOLD: result frozen, no readies.
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_rdy0", r0_ready, 0);
      check("st_rdy1", r1_ready, 0);
      check("st_data", out_data, 8'h02);
      check("st_id", out_id, 1);
      r1_in = 8'h40 + 8'(i);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    check("rel_rdy0", r0_ready, 1);
    check("rel_rdy1", r1_ready, 0);
    @(negedge clk);
    #1;
    check("rel_data", out_data, 8'h01);
    check("rel_id", out_id, 0);
    check("rel_cnt0", gnt_cnt0, 3);

    // Reset while holding: result dropped, r0 wins the next tie.
    @(negedge clk);
    rst = 1;
    #1;
    check("rh_rdy0", r0_ready, 0);
    check("rh_rdy1", r1_ready, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rh_valid", out_valid, 0);
    check("rh_cnt0", gnt_cnt0, 0);
    check("rh_cnt1", gnt_cnt1, 0);
    check("rh_tie0", r0_ready, 1);
    check("rh_tie1", r1_ready, 0);
    @(negedge clk);
    #1;
    check("rh_id", out_id, 0);
    check("rh_v2", out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
